accumulator_t_c2x2_f0_16bits: RTL and testbench

ACCUMULATOR_T_C2X2_F0_16BITS -- requirements
Module: accumulator_t_c2x2_f0_16bits

---
 rtl/accumulator_t_c2x2_f0_16bits_if.sv | 28 ++
 rtl/accumulator_t_c2x2_f0_16bits.sv | 76 +++++++
 tb/tb_accumulator_t_c2x2_f0_16bits.sv | 131 +++++++++++++
 3 files changed

// File: rtl/accumulator_t_c2x2_f0_16bits_if.sv
// accumulator_t_c2x2_f0_16bits_if: beat input and result output handshake bundle
interface accumulator_t_c2x2_f0_16bits_if #(
  parameter int ACC_WIDTH = 48,
  parameter int CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          result_0;
  logic [31:0]          result_1;
  logic [1:0]           result_SIDM_carry;
  logic                 mode;
  logic                 a_sign;
  logic                 b_sign;
  logic [CNT_WIDTH-1:0] acc_len;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 acc_mode;
  logic                 overflow;
  modport master (
    output in_valid, result_0, result_1, result_SIDM_carry, mode, a_sign, b_sign, acc_len, out_ready,
    input  in_ready, out_valid, acc_out, acc_mode, overflow
  );
  modport slave (
    input  in_valid, result_0, result_1, result_SIDM_carry, mode, a_sign, b_sign, acc_len, out_ready,
    output in_ready, out_valid, acc_out, acc_mode, overflow
  );
endinterface

// File: rtl/accumulator_t_c2x2_f0_16bits.sv
// accumulator_t_c2x2_f0_16bits: burst accumulator for 2x2 multiplier products, single or dual-lane
module accumulator_t_c2x2_f0_16bits #(
  parameter int ACC_WIDTH = 48,
  parameter int CNT_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  accumulator_t_c2x2_f0_16bits_if.slave bus
);
  localparam int W = ACC_WIDTH;
  localparam int H = ACC_WIDTH / 2;
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  state_t state, state_nx;
  logic [W-1:0] acc, p, sum;
  logic [CNT_WIDTH-1:0] count, count_nx, len, len_in;
  logic [31:0] p32;
  logic [16:0] l0, l1;
  logic [H:0] s_lo, s_hi;
  logic mode_r, sgn_r, ovf, live, xfer, md, sg, ov_lo, ov_hi, ovf_add;
  assign xfer = bus.in_valid && bus.in_ready;
  // the first beat of a burst uses the live mode/sign, later beats the latched ones
  assign md = state == IDLE ? bus.mode : mode_r;
  assign sg = state == IDLE ? (bus.a_sign | bus.b_sign) : sgn_r;
  assign p32 = bus.result_0 + bus.result_1;
  assign l0 = {bus.result_SIDM_carry[0], bus.result_0[15:0]};
  assign l1 = {bus.result_SIDM_carry[1], bus.result_1[31:16]};
  assign p = md ? {{(H-17){sg & l1[16]}}, l1, {(H-17){sg & l0[16]}}, l0}
                : {{(W-32){sg & p32[31]}}, p32};
  // lane split: the low-half carry feeds the high half only in single-product mode
  assign s_lo = {1'b0, acc[H-1:0]} + {1'b0, p[H-1:0]};
  assign s_hi = {1'b0, acc[W-1:H]} + {1'b0, p[W-1:H]} + {{H{1'b0}}, ~md & s_lo[H]};
  assign sum = {s_hi[H-1:0], s_lo[H-1:0]};
  assign ov_lo = (acc[H-1] == p[H-1]) && (sum[H-1] != acc[H-1]);
  assign ov_hi = (acc[W-1] == p[W-1]) && (sum[W-1] != acc[W-1]);
  assign ovf_add = (sg ? ov_hi : s_hi[H]) | (md & (sg ? ov_lo : s_lo[H]));
  assign len_in = bus.acc_len == '0 ? CNT_WIDTH'(1) : bus.acc_len;
  assign count_nx = count + CNT_WIDTH'(1);
  always_comb begin
    state_nx = state;
    if (state == IDLE && xfer) state_nx = len_in == CNT_WIDTH'(1) ? HOLD : ACC;
    else if (state == ACC && xfer && count_nx == len) state_nx = HOLD;
    else if (state == HOLD && bus.out_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      count  <= '0;
      len    <= '0;
      mode_r <= 1'b0;
      sgn_r  <= 1'b0;
      ovf    <= 1'b0;
      live   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (xfer) begin
        acc   <= state == IDLE ? p : sum;
        count <= state == IDLE ? CNT_WIDTH'(1) : count_nx;
        ovf   <= state == IDLE ? 1'b0 : ovf | ovf_add;
        if (state == IDLE) begin
          len    <= len_in;
          mode_r <= bus.mode;
          sgn_r  <= bus.a_sign | bus.b_sign;
        end
      end
    end
  end
  assign bus.in_ready  = live && state != HOLD;
  assign bus.out_valid = state == HOLD;
  assign bus.acc_out   = acc;
  assign bus.acc_mode  = mode_r;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_accumulator_t_c2x2_f0_16bits.sv
// tb_accumulator_t_c2x2_f0_16bits: directed and random bursts against an arithmetic reference model
module tb_accumulator_t_c2x2_f0_16bits;
  logic clk, rst_n;
  int checks = 0, errors = 0;
  accumulator_t_c2x2_f0_16bits_if bus ();
  accumulator_t_c2x2_f0_16bits dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic longint sx(input longint v, input int w, input bit s);
    return (s && v >= (longint'(1) << (w - 1))) ? v - (longint'(1) << w) : v;
  endfunction
  // value-level add into a w-bit register: wrap and flag when the true sum leaves the range
  task automatic acc_add(inout longint a, input longint p, input int w, input bit s, inout bit ov);
    longint m, n, lo, hi;
    m = longint'(1) << w;
    n = a + p;
    lo = s ? -(m / 2) : 0;
    hi = s ? m / 2 : m;
    if (n < lo) begin n += m; ov = 1'b1; end
    else if (n >= hi) begin n -= m; ov = 1'b1; end
    a = n;
  endtask
  task automatic send(input logic [31:0] r0, r1, input logic [1:0] c, input bit md, as, bs,
                      input logic [7:0] len);
    int t = 0;
    bus.result_0 = r0; bus.result_1 = r1; bus.result_SIDM_carry = c;
    bus.mode = md; bus.a_sign = as; bus.b_sign = bs; bus.acc_len = len;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 20) begin @(posedge clk); #1; t++; end
    chk("ready_wait", 64'(t < 20), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic do_burst(input bit md, as, bs, input int len, input bit rnd,
                          input logic [31:0] r0f, r1f, input logic [1:0] cf, input int hold);
    int n;
    bit sg, ov_f, ov_l;
    longint full, lo, hi, pf, l0v, l1v;
    logic [31:0] r0, r1, s32;
    logic [1:0] c;
    logic [63:0] tf, tl, th;
    logic [47:0] exp;
    n = len == 0 ? 1 : len;
    sg = as | bs; ov_f = 0; ov_l = 0; full = 0; lo = 0; hi = 0;
    for (int i = 0; i < n; i++) begin
      r0 = rnd ? $urandom : r0f;
      r1 = rnd ? $urandom : r1f;
      c = rnd ? 2'($urandom) : cf;
      s32 = r0 + r1;
      pf = sx(longint'(s32), 32, sg);
      l0v = sx(longint'({c[0], r0[15:0]}), 17, sg);
      l1v = sx(longint'({c[1], r1[31:16]}), 17, sg);
      if (i == 0) begin
        full = pf; lo = l0v; hi = l1v;
        send(r0, r1, c, md, as, bs, 8'(len));
      end else begin
        acc_add(full, pf, 48, sg, ov_f);
        acc_add(lo, l0v, 24, sg, ov_l);
        acc_add(hi, l1v, 24, sg, ov_l);
        send(r0, r1, c, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      end
      if (i < n - 1) chk("early_valid", 64'(bus.out_valid), 0);
    end
    tf = full; tl = lo; th = hi;
    exp = md ? {th[23:0], tl[23:0]} : tf[47:0];
    chk("latency_valid", 64'(bus.out_valid), 1);
    chk("hold_ready", 64'(bus.in_ready), 0);
    chk("acc_out", 64'(bus.acc_out), 64'(exp));
    chk("overflow", 64'(bus.overflow), 64'(md ? ov_l : ov_f));
    chk("acc_mode", 64'(bus.acc_mode), 64'(md));
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'b1; bus.result_0 = $urandom; bus.acc_len = 8'd1;
      @(posedge clk); #1;
      chk("stall_ready", 64'(bus.in_ready), 0);
      chk("stall_stable", 64'({bus.out_valid, bus.acc_out}), 64'({1'b1, exp}));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("drain_valid", 64'(bus.out_valid), 0);
    chk("idle_ready", 64'(bus.in_ready), 1);
  endtask
  initial begin
    int seen;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.result_0 = '0; bus.result_1 = '0;
    bus.result_SIDM_carry = '0; bus.mode = 1'b0; bus.a_sign = 1'b0; bus.b_sign = 1'b0; bus.acc_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 64'({bus.in_ready, bus.out_valid, bus.acc_mode, bus.overflow}), 0);
    chk("rst_acc", 64'(bus.acc_out), 0);
    rst_n = 1'b1;
    chk("rel_ready_low", 64'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("rel_ready_high", 64'(bus.in_ready), 1);
    do_burst(0, 0, 0, 3, 0, 32'd100, 32'd0, 2'b00, 0);
    chk("sum300", 64'(bus.acc_out), 64'd300);
    do_burst(1, 1, 0, 2, 0, 32'h0000_FFFF, 32'h0005_0000, 2'b01, 0);
    chk("lanes_signed", 64'(bus.acc_out), 64'h0000_0000_0A_FFFFFE);
    do_burst(0, 1, 1, 2, 1, 0, 0, 2'b00, 5);
    do_burst(1, 0, 0, 200, 0, 32'h0000_FFFF, 32'd0, 2'b01, 0);
    chk("lane_ovf", 64'({bus.overflow, bus.acc_out[23:0]}), 64'({1'b1, 24'h8FFF38}));
    send(32'd9, 32'd1, 2'b00, 1'b0, 1'b0, 1'b0, 8'd4);
    send(32'd9, 32'd1, 2'b00, 1'b0, 1'b0, 1'b0, 8'd4);
    rst_n = 1'b0;
    #1;
    chk("midrst_clear", 64'({bus.in_ready, bus.out_valid, bus.overflow, bus.acc_out}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; seen += int'(bus.out_valid); end
    chk("midrst_no_valid", 64'(seen), 0);
    do_burst(0, 0, 0, 1, 0, 32'd7, 32'd0, 2'b00, 0);
    chk("fresh7", 64'(bus.acc_out), 64'd7);
    do_burst(0, 0, 0, 0, 0, 32'd5, 32'd0, 2'b00, 0);
    chk("len0", 64'(bus.acc_out), 64'd5);
    for (int k = 0; k < 12; k++)
      do_burst(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 8), 1, 0, 0, 2'b00,
               $urandom_range(0, 2));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
